// File: rtl/score_bcd_counter_pkg.sv
// Shared constants and helpers for the BCD score counter.
// Pure declarations; no logic, no latency.
// No flow control.
package score_bcd_counter_pkg;

    localparam int BCD_W          = 4;
    localparam int DEFAULT_DIGITS = 4;

    localparam logic [BCD_W-1:0] BCD_MAX      = 4'd9;
    localparam logic [BCD_W-1:0] AMOUNT_CLAMP = 4'd9;

    typedef logic [BCD_W-1:0] bcd_t;

    // Point amounts above a single decimal digit are clipped to 9.
    function automatic bcd_t clamp_amount(input logic [3:0] amount);
        return (amount > AMOUNT_CLAMP) ? AMOUNT_CLAMP : amount;
    endfunction

endpackage

// File: rtl/score_bcd_counter_if.sv
// Score event inputs and shadowed digit outputs of the score counter.
// Wiring only; no latency.
// No backpressure: events are accepted every cycle.
interface score_bcd_counter_if
    import score_bcd_counter_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
);
    logic                    clr;
    logic                    inc;
    logic [3:0]              amount;
    logic                    frame_tick;
    logic [BCD_W*DIGITS-1:0] digits;
    logic [DIGITS-1:0]       blank;
    logic                    sat;
    logic                    busy_frame;

    modport master (
        output clr, inc, amount, frame_tick,
        input  digits, blank, sat, busy_frame
    );

    modport slave (
        input  clr, inc, amount, frame_tick,
        output digits, blank, sat, busy_frame
    );
endinterface

// File: rtl/score_bcd_counter_bcd_digit_add.sv
// One decimal digit of a ripple BCD adder: a + b + cin with decimal carry.
// Purely combinational.
// No flow control.
module bcd_digit_add
    import score_bcd_counter_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    input  logic cin,
    output bcd_t sum,
    output logic cout
);
    logic [BCD_W:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        sum  = raw[BCD_W-1:0];
        cout = 1'b0;
        if (raw > {1'b0, BCD_MAX}) begin
            sum  = raw[BCD_W-1:0] - 4'd10;
            cout = 1'b1;
        end
    end
endmodule

// File: rtl/score_bcd_counter.sv
// Saturating BCD score accumulator with frame-synchronous shadow digits and blanking.
// inc -> live count 1 cycle; frame_tick -> digits/blank 1 cycle; busy_frame lags 1 cycle.
// No backpressure: inc/clr/frame_tick are honoured every cycle.
module score_bcd_counter
    import score_bcd_counter_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
)(
    input  logic                clk,
    input  logic                reset,
    score_bcd_counter_if.slave  bus
);
    localparam int W = BCD_W * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    logic [W-1:0]      live_q;
    logic [W-1:0]      shadow_q;
    logic [W-1:0]      live_sum;
    logic [W-1:0]      all_nines;
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_nxt;
    logic              sat_q;
    logic              busy_q;
    logic              zero_above;
    bcd_t              amt;

    assign amt      = clamp_amount(bus.amount);
    assign carry[0] = 1'b0;

    // Only the units digit receives the addend; higher digits see carry only.
    for (genvar i = 0; i < DIGITS; i++) begin : g_add
        bcd_digit_add u_add (
            .a    (live_q[BCD_W*i +: BCD_W]),
            .b    ((i == 0) ? amt : bcd_t'(0)),
            .cin  (carry[i]),
            .sum  (live_sum[BCD_W*i +: BCD_W]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        all_nines = '0;
        for (int i = 0; i < DIGITS; i++) begin
            all_nines[BCD_W*i +: BCD_W] = BCD_MAX;
        end
    end

    // Leading-zero mask from the pre-edge live count; units digit never blanked.
    always_comb begin
        zero_above = 1'b1;
        blank_nxt  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (live_q[BCD_W*i +: BCD_W] == bcd_t'(0));
            blank_nxt[i] = zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live_q   <= '0;
            shadow_q <= '0;
            blank_q  <= BLANK_RST;
            sat_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            busy_q <= (live_q != shadow_q);
            if (bus.frame_tick) begin
                shadow_q <= live_q;
                blank_q  <= blank_nxt;
            end
            if (bus.clr) begin
                live_q <= '0;
                sat_q  <= 1'b0;
            end else if (bus.inc) begin
                if (carry[DIGITS]) begin
                    live_q <= all_nines;
                    sat_q  <= 1'b1;
                end else begin
                    live_q <= live_sum;
                end
            end
        end
    end

    assign bus.digits     = shadow_q;
    assign bus.blank      = blank_q;
    assign bus.sat        = sat_q;
    assign bus.busy_frame = busy_q;
endmodule

// File: tb/tb_score_bcd_counter.sv
// Scoreboard bench: integer-valued score model predicts every cycle's outputs,
// a monitor compares them against the DUT shortly after each rising edge.
module tb_score_bcd_counter;
    import score_bcd_counter_pkg::*;

    localparam int D    = 4;
    localparam int MAXV = 9999;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    score_bcd_counter_if #(.DIGITS(D)) bus ();

    score_bcd_counter #(.DIGITS(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4*D-1:0] digits;
        logic [D-1:0]   blank;
        logic           sat;
        logic           busy;
        string          tag;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    int         m_live   = 0;
    int         m_shadow = 0;
    bit         m_sat    = 0;
    bit         m_busy   = 0;
    logic [D-1:0] m_blank = '0;

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        r = '0;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [D-1:0] blank_of(input int v);
        int           p;
        logic [D-1:0] b;
        p = 1;
        b = '0;
        for (int k = 1; k < D; k++) begin
            p    = p * 10;
            b[k] = (v < p);
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and predict the outputs after the next edge.
    task automatic step(input bit r, input bit c, input bit i, input int amt,
                        input bit ft, input string tag);
        exp_t e;
        int   a;
        int   old_live;
        int   old_shadow;
        @(negedge clk);
        reset          = r;
        bus.clr        = c;
        bus.inc        = i;
        bus.amount     = amt[3:0];
        bus.frame_tick = ft;
        old_live   = m_live;
        old_shadow = m_shadow;
        if (r) begin
            m_live = 0; m_shadow = 0; m_sat = 0; m_busy = 0;
            m_blank = blank_of(0);
        end else begin
            m_busy = (old_live != old_shadow);
            if (ft) begin
                m_shadow = old_live;
                m_blank  = blank_of(old_live);
            end
            if (c) begin
                m_live = 0;
                m_sat  = 0;
            end else if (i) begin
                a = (amt > 9) ? 9 : amt;
                if (old_live + a > MAXV) begin
                    m_live = MAXV;
                    m_sat  = 1;
                end else begin
                    m_live = old_live + a;
                end
            end
        end
        e.digits = to_bcd(m_shadow);
        e.blank  = m_blank;
        e.sat    = m_sat;
        e.busy   = m_busy;
        e.tag    = tag;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, tag);
    endtask

    task automatic add_to(input int target);
        while (m_live < target)
            step(0, 0, 1, (target - m_live > 9) ? 9 : target - m_live, 0, "preload");
    endtask

    // Monitor: every edge with a pending prediction is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".digits"}, 32'(bus.digits),     32'(e.digits));
                chk({e.tag, ".blank"},  32'(bus.blank),      32'(e.blank));
                chk({e.tag, ".sat"},    32'(bus.sat),        32'(e.sat));
                chk({e.tag, ".busy"},   32'(bus.busy_frame), 32'(e.busy));
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.clr = 1'b0; bus.inc = 1'b0; bus.amount = '0; bus.frame_tick = 1'b0;

        // Reset and empty frame
        step(1, 0, 0, 0, 0, "reset");
        step(0, 0, 0, 0, 1, "t1_ft");
        idle("t1_idle");

        // Back-to-back incs, shadow stays old until frame_tick
        step(0, 0, 1, 7, 0, "t2_inc7");
        step(0, 0, 1, 5, 0, "t2_inc5");
        idle("t2_hold");
        step(0, 0, 0, 0, 1, "t2_ft");
        idle("t2_after");

        // Triple carry ripple 999 -> 1000
        step(1, 0, 0, 0, 0, "t3_reset");
        add_to(999);
        step(0, 0, 1, 1, 0, "t3_inc1");
        step(0, 0, 0, 0, 1, "t3_ft");
        idle("t3_after");

        // Saturation with clamped amount, then clear
        step(1, 0, 0, 0, 0, "t4_reset");
        add_to(9995);
        step(0, 0, 1, 15, 0, "t4_inc15");
        step(0, 0, 0, 0, 1, "t4_ft");
        step(0, 0, 1, 3, 0, "t4_inc_at_max");
        step(0, 0, 1, 0, 0, "t4_inc_zero");
        step(0, 0, 0, 0, 1, "t4_ft2");
        step(0, 0, 0, 0, 0, "t4_idle");
        step(0, 1, 0, 0, 0, "t4_clr");
        step(0, 0, 0, 0, 1, "t4_ft3");
        idle("t4_after");

        // Exact landing on all nines does not saturate
        add_to(9990);
        step(0, 0, 1, 9, 0, "t4b_exact");
        step(0, 0, 0, 0, 1, "t4b_ft");

        // frame_tick and inc together
        step(1, 0, 0, 0, 0, "t5_reset");
        add_to(40);
        step(0, 0, 1, 3, 1, "t5_ft_inc");
        step(0, 0, 0, 0, 1, "t5_ft");
        idle("t5_after");

        // clr beats inc; all three together; mid-sequence reset
        step(1, 0, 0, 0, 0, "t6_reset");
        add_to(20);
        step(0, 1, 1, 4, 0, "t6_clr_inc");
        step(0, 0, 0, 0, 1, "t6_ft");
        add_to(35);
        step(0, 1, 1, 6, 1, "t6_all3");
        step(0, 0, 0, 0, 1, "t6_ft2");
        step(0, 0, 1, 8, 0, "t6_inc8");
        step(0, 0, 0, 0, 1, "t6_ft3");
        step(1, 0, 1, 5, 1, "t6_midreset");
        idle("t6_after");

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            step(($urandom_range(0, 2999) == 0),
                 ($urandom_range(0, 2499) == 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 11) == 0),
                 "rand");
        end
        idle("final");

        repeat (5) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
Multi-digit BCD score counter that produces the per-digit 4-bit values consumed by the on-screen digit renderers.
- Game logic pulses score events with a point amount.
- The block accumulates the score in BCD with saturation.
- Digits are presented through a shadow register that updates only on a frame tick, so digit renderers never see a value change mid-frame.
- Also supplies a leading-zero blanking mask.

Parameters:
DIGITS, 4, number of BCD digits (score range 0 to 10^DIGITS-1)

Ports:
clk  input  1  system clock (pixel-clock domain)
reset  input  1  synchronous, active-high reset
clr  input  1  synchronous score clear; one-cycle pulse
inc  input  1  score event strobe; one-cycle pulse
amount  input  4  points to add on inc; values 10-15 are clamped to 9
frame_tick  input  1  one-cycle pulse at start of vertical blank
digits  output  4*DIGITS  shadowed BCD digits; digit i at [4i+3:4i]; digit 0 is units
blank  output  DIGITS  shadowed leading-zero mask; bit i=1 means suppress digit i
sat  output  1  sticky saturation flag
busy_frame  output  1  live count differs from shadowed digits

Behaviour:
- Reset (clk edge with reset=1):
  - live count = 0, shadow = 0, digits = 0.
  - blank = all ones except bit 0, so units "0" is always shown.
  - sat = 0, busy_frame = 0.
  - reset overrides every other input.
- Live count register: DIGITS BCD digits, each always 0-9; no illegal BCD code is ever stored.
- Add path, when inc=1 and clr=0:
  - amt = (amount>9) ? 9 : amount.
  - Add amt to digit 0, then ripple a decimal carry digit by digit (digit sum>9 -> subtract 10, carry 1).
  - Fully combinational; result registered on the same edge, so latency is 1 cycle from inc to live count.
- Saturation:
  - If the carry out of the top digit is 1, the live count becomes all nines and sat is set.
  - sat stays set until clr or reset.
  - Further inc while at all nines leaves the count unchanged.
- amt=0 with inc=1: count unchanged; sat unchanged.
- clr=1: live count = 0 and sat = 0 on the next edge. clr has priority over a simultaneous inc.
- Shadow update on frame_tick=1:
  - On that edge, shadow/digits capture the live count as it stood before the edge; an inc in the same cycle is not visible until the next frame_tick.
  - blank is recomputed from the captured value on the same edge.
  - Latency: frame_tick to digits is 1 cycle.
- blank rule:
  - bit i=1 iff digit i and all digits above it are 0, for i>=1.
  - bit 0 is always 0.
- Outside frame_tick, digits and blank hold.
- busy_frame is registered: 1 whenever live count != shadow, evaluated each cycle (1-cycle lag).
- Simultaneous frame_tick, inc and clr: shadow captures the pre-edge count; live count clears.
- No handshake back to game logic. inc is accepted every cycle, including back-to-back.

Decomposition:
- Shared package: BCD_W=4, BCD_MAX=9, AMOUNT_CLAMP=9, default DIGITS=4.
- One natural sub-module, bcd_digit_add:
  - Inputs: 4-bit digit a, 4-bit addend b (0-9), carry in.
  - Outputs: 4-bit sum digit, carry out.
  - Purely combinational; instantiated DIGITS times in a ripple chain (addend nonzero only for digit 0).
- Top level holds the live register, shadow register, sat, blank and busy_frame logic.

Test Plan:
1. Reset, then frame_tick -> digits=0x0000, blank=4'b1110, sat=0, busy_frame=0.
2. inc amount=7, then inc amount=5 back-to-back, then frame_tick -> digits=0x0012, blank=4'b1100; before frame_tick, digits still 0x0000 and busy_frame=1.
3. Preload via incs to 0x0999, then inc amount=1, then frame_tick -> digits=0x1000 (triple carry ripple), blank=4'b0000.
4. Live 0x9995, inc amount=15 (clamped to 9), then frame_tick -> digits=0x9999, sat=1. Another inc keeps 0x9999. clr -> next frame_tick gives 0x0000, sat=0.
5. Same-cycle frame_tick + inc amount=3 with live 0x0040 -> digits=0x0040 after that edge; next frame_tick -> 0x0043.
6. clr and inc amount=4 in the same cycle with live 0x0020, then frame_tick -> digits=0x0000. Reset asserted mid-sequence -> all outputs return to reset values on the next edge.
